// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD batch requester: data width, table depth,
// controller state encoding and the operand-pair record stored per job.
package gcd_pkg;

    localparam int DATA_W      = 16;
    localparam int TABLE_DEPTH = 4;
    localparam int IDX_W       = $clog2(TABLE_DEPTH);

    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_REPORT = 3'd3,
        S_FIN    = 3'd4
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } job_t;

endpackage

// File: rtl/gcd_batch_requester_if.sv
// Start/done handshake between the batch requester (master) and a GCD
// datapath (slave). Result is only meaningful while gcd_done is high.
interface gcd_batch_requester_if #(
    parameter int DATA_W = gcd_pkg::DATA_W
);
    logic              gcd_start;
    logic [DATA_W-1:0] gcd_a;
    logic [DATA_W-1:0] gcd_b;
    logic              gcd_done;
    logic [DATA_W-1:0] gcd_result;

    modport master (
        output gcd_start, gcd_a, gcd_b,
        input  gcd_done, gcd_result
    );

    modport slave (
        input  gcd_start, gcd_a, gcd_b,
        output gcd_done, gcd_result
    );
endinterface

// File: rtl/gcd_operand_table.sv
// Four-entry operand-pair register file: one synchronous write port and one
// combinational read port. Reset clears every entry so a batch run straight
// after reset sees all-zero pairs.
module gcd_operand_table
    import gcd_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic we,
    input  idx_t wr_idx,
    input  job_t wr_data,
    input  idx_t rd_idx,
    output job_t rd_data
);

    job_t mem [TABLE_DEPTH];

    // Entry storage with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TABLE_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/gcd_batch_requester.sv
// Initiator side of the GCD start/done handshake. Runs up to four operand
// pairs from a local table through an external GCD unit, reporting each
// result with a one-cycle valid pulse. Pairs with a zero operand bypass the
// unit, and a per-job watchdog abandons a job that never completes.
// Every output is a register loaded from the next-state decode.
module gcd_batch_requester
    import gcd_pkg::*;
#(
    parameter int DATA_W  = gcd_pkg::DATA_W,
    parameter int TIMEOUT = 65600,
    parameter int CNT_W   = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  go,
    input  logic [2:0]            num_jobs,
    input  logic                  load_we,
    input  logic [1:0]            load_idx,
    input  logic [DATA_W-1:0]     load_a,
    input  logic [DATA_W-1:0]     load_b,
    gcd_batch_requester_if.master gcd,
    output logic                  busy,
    output logic                  res_valid,
    output logic [1:0]            res_idx,
    output logic [DATA_W-1:0]     res_gcd,
    output logic                  batch_done,
    output logic                  timeout_err
);

    localparam logic [CNT_W-1:0] TMAX = CNT_W'(TIMEOUT - 1);

    // Index of the final job: num_jobs saturated to the table depth, minus one.
    // Only called with num_jobs > 0.
    function automatic idx_t last_job(input logic [2:0] n);
        logic [2:0] sat;
        sat = (n > 3'd4) ? 3'd4 : n;
        return idx_t'(sat - 3'd1);
    endfunction

    state_t            state_q, state_d;
    idx_t              idx_q, idx_d;
    idx_t              last_q, last_d;
    logic [CNT_W-1:0]  timer_q, timer_d;
    logic              start_q, start_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic              busy_q, busy_d;
    logic              rv_q, rv_d;
    idx_t              ridx_q, ridx_d;
    logic [DATA_W-1:0] rgcd_q, rgcd_d;
    logic              bd_q, bd_d;
    logic              terr_q, terr_d;
    logic              tbl_we;
    job_t              wr_job;
    job_t              rd_job;

    assign wr_job.a = load_a;
    assign wr_job.b = load_b;

    // The read port looks ahead at the job about to be issued so that the
    // operand registers and start pulse are loaded on the edge into ISSUE.
    gcd_operand_table u_table (
        .clk     (clk),
        .rst     (rst),
        .we      (tbl_we),
        .wr_idx  (load_idx),
        .wr_data (wr_job),
        .rd_idx  (idx_d),
        .rd_data (rd_job)
    );

    // Next-state, job sequencing, watchdog and result capture.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        timer_d = timer_q;
        rv_d    = 1'b0;
        ridx_d  = ridx_q;
        rgcd_d  = rgcd_q;
        bd_d    = 1'b0;
        terr_d  = terr_q;
        tbl_we  = 1'b0;

        case (state_q)
            S_IDLE: begin
                tbl_we = load_we;
                if (go) begin
                    if (num_jobs == 3'd0) begin
                        bd_d = 1'b1;
                    end else begin
                        last_d  = last_job(num_jobs);
                        idx_d   = '0;
                        terr_d  = 1'b0;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                // gcd(x,0)=x and gcd(0,0)=0, so a|b is the answer directly.
                if ((a_q == '0) || (b_q == '0)) begin
                    rgcd_d  = a_q | b_q;
                    rv_d    = 1'b1;
                    ridx_d  = idx_q;
                    state_d = S_REPORT;
                end else begin
                    timer_d = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A done arriving on the final watchdog cycle still counts.
                if (gcd.gcd_done) begin
                    rgcd_d  = gcd.gcd_result;
                    rv_d    = 1'b1;
                    ridx_d  = idx_q;
                    state_d = S_REPORT;
                end else if (timer_q == TMAX) begin
                    rgcd_d  = '0;
                    terr_d  = 1'b1;
                    rv_d    = 1'b1;
                    ridx_d  = idx_q;
                    state_d = S_REPORT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_REPORT: begin
                if (idx_q == last_q) begin
                    bd_d    = 1'b1;
                    state_d = S_FIN;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign start_d = (state_d == S_ISSUE) && (rd_job.a != '0) && (rd_job.b != '0);
    assign a_d     = (state_d == S_ISSUE) ? rd_job.a : a_q;
    assign b_d     = (state_d == S_ISSUE) ? rd_job.b : b_q;
    assign busy_d  = (state_d != S_IDLE);

    // State and registered outputs; reset aborts any batch in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            last_q  <= '0;
            timer_q <= '0;
            start_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            busy_q  <= 1'b0;
            rv_q    <= 1'b0;
            ridx_q  <= '0;
            rgcd_q  <= '0;
            bd_q    <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            timer_q <= timer_d;
            start_q <= start_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            rv_q    <= rv_d;
            ridx_q  <= ridx_d;
            rgcd_q  <= rgcd_d;
            bd_q    <= bd_d;
            terr_q  <= terr_d;
        end
    end

    assign gcd.gcd_start = start_q;
    assign gcd.gcd_a     = a_q;
    assign gcd.gcd_b     = b_q;
    assign busy          = busy_q;
    assign res_valid     = rv_q;
    assign res_idx       = ridx_q;
    assign res_gcd       = rgcd_q;
    assign batch_done    = bd_q;
    assign timeout_err   = terr_q;

endmodule
